// File: rtl/gate_test_pkg.sv
// gate_test_pkg: shared state type and 3-input gate truth tables
package gate_test_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [7:0] NAND3_TT = 8'h7F;
  localparam logic [7:0] AND3_TT  = 8'h80;
  localparam logic [7:0] OR3_TT   = 8'hFE;
  localparam logic [7:0] NOR3_TT  = 8'h01;
  localparam logic [7:0] XOR3_TT  = 8'h96;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with async active-low reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sync_q, meta_q} <= 2'b00;
    else {sync_q, meta_q} <= {meta_q, d};
  assign q = sync_q;
endmodule

// File: rtl/gate3_tester.sv
// gate3_tester: walks a 3-input gate through all vectors and checks it against a truth table
module gate3_tester
  import gate_test_pkg::*;
#(
  parameter logic [7:0]  EXPECT        = NAND3_TT,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_mask
);
  state_t state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d, mask_q, mask_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic y_sync, last, hit;
  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(dut_y), .q(y_sync));
  assign last = cnt_q == 8'(SETTLE_CYCLES - 1);
  assign hit  = y_sync != EXPECT[vec_q];
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    if (abort || !(state_q inside {IDLE, RUN, DONE})) begin
      state_d = IDLE;
      vec_d   = '0;
      cnt_d   = '0;
      mask_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else if (state_q != RUN) begin
      if (start) begin
        state_d = RUN;
        vec_d   = '0;
        cnt_d   = '0;
        mask_d  = '0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    end else if (!last) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      mask_d = mask_q | (8'(hit) << vec_q);
      cnt_d  = '0;
      if (vec_q != 3'd7) vec_d = vec_q + 3'd1;
      else begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = mask_d == 8'h00;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  assign {dut_a, dut_b, dut_c} = vec_q;
  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = mask_q;
endmodule

// File: tb/tb_gate3_tester.sv
// tb_gate3_tester: three tester instances against a modelled gate, scoreboarded per instance
module tb_gate3_tester;
  import gate_test_pkg::*;
  typedef struct {logic [7:0] mask; int cyc;} exp_t;
  localparam logic [7:0] EXP_TAB [3] = '{NAND3_TT, NAND3_TT, AND3_TT};
  localparam int S_TAB [3] = '{4, 3, 4};
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [2:0] a, b, c, busy, done, pass, y;
  logic [2:0] vi [3];
  logic [7:0] fm [3];
  logic [7:0] g_tt = NAND3_TT;
  logic g_lag = 0;
  int cyc = 0, n_cmp = 0, n_fail = 0;
  logic [2:0] prev [3] = '{3'd0, 3'd0, 3'd0};
  logic [2:0] done_prev = 3'b000;
  exp_t q0[$], q1[$], q2[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : gi
    logic lq;
    gate3_tester #(.EXPECT(EXP_TAB[g]), .SETTLE_CYCLES(S_TAB[g])) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_y(y[g]),
      .dut_a(a[g]), .dut_b(b[g]), .dut_c(c[g]), .vec_idx(vi[g]),
      .busy(busy[g]), .done(done[g]), .pass(pass[g]), .fail_mask(fm[g]));
    always @(posedge clk or negedge rst_n)
      if (!rst_n) lq <= g_tt[0];
      else lq <= g_tt[{a[g], b[g], c[g]}];
    assign y[g] = g_lag ? lq : g_tt[{a[g], b[g], c[g]}];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // Gate output seen by vector i is the one present S-3 clocks after it is applied;
  // a one-clock-lagged gate still shows the previous vector's result at offset 0.
  function automatic logic [7:0] exp_mask(input logic [7:0] tt, input logic lag, input int s,
                                          input logic [7:0] ex, input logic [2:0] pv);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      int src;
      src = (lag && s - 3 < 1) ? (i == 0 ? int'(pv) : i - 1) : i;
      m[i] = tt[src] != ex[i];
    end
    return m;
  endfunction
  task automatic push(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask
  task automatic drop_all();
    q0.delete(); q1.delete(); q2.delete();
    for (int k = 0; k < 3; k++) prev[k] = 3'd0;
  endtask
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("abc_eq_idx%0d", k), {a[k], b[k], c[k]}, vi[k]);
      chk($sformatf("pass_inv%0d", k), pass[k], done[k] && fm[k] == 8'h00);
      if (done[k] && !done_prev[k]) begin
        exp_t e;
        int n;
        n = k == 0 ? q0.size() : k == 1 ? q1.size() : q2.size();
        if (n == 0) chk($sformatf("unexpected_done%0d", k), done[k], 1'b0);
        else begin
          e = k == 0 ? q0.pop_front() : k == 1 ? q1.pop_front() : q2.pop_front();
          chk($sformatf("fail_mask%0d", k), fm[k], e.mask);
          chk($sformatf("pass%0d", k), pass[k], e.mask == 8'h00);
          chk($sformatf("done_cycle%0d", k), cyc, e.cyc);
          chk($sformatf("busy_at_done%0d", k), busy[k], 1'b0);
          prev[k] = 3'd7;
        end
      end
    end
    done_prev = done;
  end
  task automatic pulse_start(output int e0);
    @(negedge clk);
    start = 1;
    e0 = cyc + 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_all();
    for (int t = 0; t < 400 && (q0.size() + q1.size() + q2.size()) != 0; t++) @(negedge clk);
    chk("timeout_pending", q0.size() + q1.size() + q2.size(), 0);
    @(negedge clk);
  endtask
  task automatic run(input logic [7:0] tt, input logic lag, input bit repulse);
    int e0;
    @(negedge clk);
    g_tt = tt;
    g_lag = lag;
    repeat (2) @(negedge clk);
    pulse_start(e0);
    for (int k = 0; k < 3; k++)
      push(k, '{exp_mask(tt, lag, S_TAB[k], EXP_TAB[k], prev[k]), e0 + 8 * S_TAB[k]});
    if (repulse) begin
      repeat (3) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
    end
    wait_all();
  endtask
  task automatic chk_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_busy%0d", tag, k), busy[k], 1'b0);
      chk($sformatf("%s_done%0d", tag, k), done[k], 1'b0);
      chk($sformatf("%s_pass%0d", tag, k), pass[k], 1'b0);
      chk($sformatf("%s_abc%0d", tag, k), {a[k], b[k], c[k]}, 3'd0);
      chk($sformatf("%s_mask%0d", tag, k), fm[k], 8'h00);
    end
  endtask
  initial begin
    int e0;
    #2 chk_zero("reset");
    @(negedge clk);
    rst_n = 1;
    run(NAND3_TT, 0, 0);
    run(8'hFF, 0, 0);
    run(8'h00, 0, 0);
    run(AND3_TT, 0, 0);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    drop_all();
    chk_zero("abort_done");
    run(NAND3_TT, 1, 0);
    run(NAND3_TT, 1, 0);
    for (int r = 0; r < 8; r++) run(8'($urandom), 1'($urandom_range(0, 1)), 0);
    pulse_start(e0);
    while (cyc < e0 + 9) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    drop_all();
    chk_zero("abort_run");
    abort = 1;
    start = 1;
    @(negedge clk);
    abort = 0;
    start = 0;
    @(negedge clk);
    chk_zero("abort_start");
    run(NAND3_TT, 0, 0);
    run(NAND3_TT, 0, 1);
    run(8'($urandom), 1, 1);
    pulse_start(e0);
    while (cyc < e0 + 16) @(negedge clk);
    #2 rst_n = 0;
    #1 chk_zero("async_rst");
    drop_all();
    @(negedge clk);
    rst_n = 1;
    run(NAND3_TT, 1, 0);
    run(8'($urandom), 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
